uart_mmio: RTL



---
 rtl/uart_mmio.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART for the picorv32 native bus.
// Registers (addr[3:2]): 0 DATA, 1 STATUS, 2 DIV, 3 IRQ_EN.
// Optional build macro UART_LOOPBACK_EN: adds IRQ_EN[2] internal loopback.

module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_pop_s;
  logic          do_push_s;

  // a pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  assign dout      = mem_r[rd_ptr_r];
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module uart_mmio #(
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int DEFAULT_DIV = 139
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);
`ifdef UART_LOOPBACK_EN
  localparam logic LOOP_OK = 1'b1;
`else
  localparam logic LOOP_OK = 1'b0;
`endif

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                            RX_WAIT = 3'd4} rx_state_t;

  logic        ready_r, irq_r, tx_ovf_r, rx_ovr_r, rx_ferr_r;
  logic [31:0] rdata_r, rd_val_s;
  logic [15:0] div_r, div_mix_s, div_new_s;
  logic [2:0]  irq_en_r;
  logic [1:0]  sel_s;
  logic        acc_s, rd_s, wr_s, div_wr_s, en_wr_s, flag_clr_s;
  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_idle_s, tx_ovf_set_s;
  logic [7:0]  tx_dout_s;
  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_ovr_set_s, rx_ferr_set_s;
  logic [7:0]  rx_dout_s;
  tx_state_t   tx_state_r, tx_state_nxt_s;
  logic [15:0] tx_cnt_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        tx_line_r, tx_end_s;
  rx_state_t   rx_state_r, rx_state_nxt_s;
  logic [15:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_in_s, rx_meta_r, rx_sync_r, rx_prev_r, rx_end_s;
  logic        unused_s;

  assign unused_s = &{1'b0, addr[31:4], addr[1:0], wdata[31:16]};

  // bus decode: an access is accepted on the edge that raises ready
  assign sel_s        = addr[3:2];
  assign acc_s        = valid && !ready_r;
  assign rd_s         = acc_s && (wstrb == 4'd0);
  assign wr_s         = acc_s && (wstrb != 4'd0);
  assign tx_push_s    = wr_s && (sel_s == 2'd0) && wstrb[0];
  assign rx_pop_s     = rd_s && (sel_s == 2'd0);
  assign flag_clr_s   = wr_s && (sel_s == 2'd1) && wstrb[0];
  assign div_wr_s     = wr_s && (sel_s == 2'd2) && (wstrb[1:0] != 2'd0);
  assign en_wr_s      = wr_s && (sel_s == 2'd3) && wstrb[0];
  assign tx_idle_s    = tx_empty_s && (tx_state_r == TX_IDLE);
  assign tx_ovf_set_s = tx_push_s && tx_full_s && !tx_pop_s;
  assign rx_ovr_set_s = rx_push_s && rx_full_s && !rx_pop_s;
  assign div_mix_s    = {wstrb[1] ? wdata[15:8] : div_r[15:8], wstrb[0] ? wdata[7:0] : div_r[7:0]};
  assign div_new_s    = (div_mix_s < 16'd4) ? 16'd4 : div_mix_s;
  assign ready        = ready_r;
  assign rdata        = rdata_r;
  assign irq          = irq_r;

`ifdef UART_LOOPBACK_EN
  assign rx_in_s = irq_en_r[2] ? tx_line_r : rx;
  assign tx      = irq_en_r[2] ? 1'b1 : tx_line_r;
`else
  assign rx_in_s = rx;
  assign tx      = tx_line_r;
`endif

  uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push_s), .din(wdata[7:0]),
    .pop(tx_pop_s), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s));

  uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push_s), .din(rx_shift_r),
    .pop(rx_pop_s), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s));

  // register read mux
  always_comb begin
    rd_val_s = 32'd0;
    case (sel_s)
      2'd0:    rd_val_s = rx_empty_s ? 32'h8000_0000 : {24'd0, rx_dout_s};
      2'd1:    rd_val_s = {26'd0, tx_ovf_r, rx_ferr_r, rx_ovr_r, !rx_empty_s, tx_idle_s, tx_full_s};
      2'd2:    rd_val_s = {16'd0, div_r};
      2'd3:    rd_val_s = {29'd0, irq_en_r};
      default: rd_val_s = 32'd0;
    endcase
  end

  // bus handshake, control registers, sticky flags (set wins over clear), irq
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_r   <= 1'b0;
      rdata_r   <= 32'd0;
      div_r     <= DIV_RST;
      irq_en_r  <= 3'd0;
      tx_ovf_r  <= 1'b0;
      rx_ovr_r  <= 1'b0;
      rx_ferr_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      ready_r   <= acc_s;
      rdata_r   <= rd_s ? rd_val_s : 32'd0;
      if (div_wr_s) div_r <= div_new_s;
      if (en_wr_s)  irq_en_r <= {LOOP_OK & wdata[2], wdata[1:0]};
      tx_ovf_r  <= tx_ovf_set_s  | (tx_ovf_r  & ~(flag_clr_s & wdata[5]));
      rx_ferr_r <= rx_ferr_set_s | (rx_ferr_r & ~(flag_clr_s & wdata[4]));
      rx_ovr_r  <= rx_ovr_set_s  | (rx_ovr_r  & ~(flag_clr_s & wdata[3]));
      irq_r     <= (irq_en_r[0] & !rx_empty_s) | (irq_en_r[1] & tx_idle_s);
    end
  end

  // TX next-state: pop a byte when leaving IDLE or at the end of STOP
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_pop_s       = 1'b0;
    tx_end_s       = (tx_cnt_r == 16'd0);
    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_empty_s) begin
          tx_pop_s       = 1'b1;
          tx_state_nxt_s = TX_START;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_START: tx_state_nxt_s = tx_end_s ? TX_DATA : TX_START;
      TX_DATA:  tx_state_nxt_s = (tx_end_s && (tx_bit_r == 3'd7)) ? TX_STOP : TX_DATA;
      TX_STOP: begin
        if (tx_end_s && !tx_empty_s) begin
          tx_pop_s       = 1'b1;
          tx_state_nxt_s = TX_START;
        end else if (tx_end_s) begin
          tx_state_nxt_s = TX_IDLE;
        end else begin
          tx_state_nxt_s = TX_STOP;
        end
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tx_state_r <= TX_IDLE;
    else         tx_state_r <= tx_state_nxt_s;
  end

  // TX datapath: bit counter reloads from div only at bit boundaries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_line_r  <= 1'b1;
    end else if (tx_pop_s) begin
      tx_shift_r <= tx_dout_s;
      tx_cnt_r   <= div_r - 16'd1;
      tx_bit_r   <= 3'd0;
      tx_line_r  <= 1'b0;
    end else if ((tx_state_r != TX_IDLE) && tx_end_s) begin
      tx_cnt_r <= div_r - 16'd1;
      case (tx_state_r)
        TX_START: tx_line_r <= tx_shift_r[0];
        TX_DATA: begin
          tx_line_r  <= (tx_bit_r == 3'd7) ? 1'b1 : tx_shift_r[1];
          tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          tx_bit_r   <= tx_bit_r + 3'd1;
        end
        default: tx_line_r <= 1'b1;
      endcase
    end else if (tx_state_r != TX_IDLE) begin
      tx_cnt_r <= tx_cnt_r - 16'd1;
    end
  end

  // RX input synchronizer and edge-detect history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_in_s;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX next-state and push / error strobes
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_push_s      = 1'b0;
    rx_ferr_set_s  = 1'b0;
    rx_end_s       = (rx_cnt_r == 16'd0);
    case (rx_state_r)
      RX_IDLE:  rx_state_nxt_s = (rx_prev_r && !rx_sync_r) ? RX_START : RX_IDLE;
      RX_START: rx_state_nxt_s = !rx_end_s ? RX_START : (rx_sync_r ? RX_IDLE : RX_DATA);
      RX_DATA:  rx_state_nxt_s = (rx_end_s && (rx_bit_r == 3'd7)) ? RX_STOP : RX_DATA;
      RX_STOP: begin
        if (rx_end_s && rx_sync_r) begin
          rx_push_s      = 1'b1;
          rx_state_nxt_s = RX_IDLE;
        end else if (rx_end_s) begin
          rx_ferr_set_s  = 1'b1;
          rx_state_nxt_s = RX_WAIT;
        end else begin
          rx_state_nxt_s = RX_STOP;
        end
      end
      RX_WAIT:  rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_WAIT;
      default:  rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rx_state_r <= RX_IDLE;
    else         rx_state_r <= rx_state_nxt_s;
  end

  // RX datapath: half-bit delay to mid-start, then full-bit sample spacing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else if (rx_state_r == RX_IDLE) begin
      rx_cnt_r <= {1'b0, div_r[15:1]} - 16'd1;
      rx_bit_r <= 3'd0;
    end else if (rx_end_s) begin
      rx_cnt_r <= div_r - 16'd1;
      if (rx_state_r == RX_DATA) begin
        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
        rx_bit_r   <= rx_bit_r + 3'd1;
      end
    end else begin
      rx_cnt_r <= rx_cnt_r - 16'd1;
    end
  end
endmodule
